// File: rtl/axis_splitter_pkg.sv
// ============================================================================
//  Module      : axis_splitter_pkg
//  Description : Shared AXI-Stream utility types: holding-register state
//                encoding and keep-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package axis_splitter_pkg;

    // Holding-register occupancy for stream width converters.
    typedef enum logic [0:0] {
        AXIS_ST_EMPTY = 1'b0,
        AXIS_ST_HOLD  = 1'b1
    } axis_state_e;

    // One tkeep bit per data byte.
    function automatic int axis_keep_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage : axis_splitter_pkg

`default_nettype wire

// File: rtl/axis_splitter.sv
// ============================================================================
//  Module      : axis_splitter
//  Description : Splits one wide AXI-Stream beat into RATIO narrow beats,
//                LSB segment first, tuser replicated on every segment.
//                Optional macro AXIS_SPLITTER_SKIP_EMPTY_EN drops trailing
//                all-zero-tkeep segments.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axis_splitter
    import axis_splitter_pkg::*;
#(
    parameter int IN_TDATA_WIDTH  = 256,
    parameter int OUT_TDATA_WIDTH = 64,
    parameter int TUSER_WIDTH     = 128
) (
    input  logic                         axis_aclk,
    input  logic                         axis_resetn,

    input  logic [IN_TDATA_WIDTH-1:0]    axis_wide_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]  axis_wide_tkeep,
    input  logic [TUSER_WIDTH-1:0]       axis_wide_tuser,
    input  logic                         axis_wide_tvalid,
    input  logic                         axis_wide_tlast,
    output logic                         axis_wide_tready,

    output logic [OUT_TDATA_WIDTH-1:0]   axis_narrow_tdata,
    output logic [OUT_TDATA_WIDTH/8-1:0] axis_narrow_tkeep,
    output logic [TUSER_WIDTH-1:0]       axis_narrow_tuser,
    output logic                         axis_narrow_tvalid,
    output logic                         axis_narrow_tlast,
    input  logic                         axis_narrow_tready
);

    localparam int RATIO      = IN_TDATA_WIDTH / OUT_TDATA_WIDTH;
    localparam int IN_KEEP_W  = axis_keep_width(IN_TDATA_WIDTH);
    localparam int OUT_KEEP_W = axis_keep_width(OUT_TDATA_WIDTH);
    localparam int SEG_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(RATIO - 1);

    axis_state_e               r_state;
    axis_state_e               w_state_nxt;
    logic [SEG_W-1:0]          r_seg;
    logic [SEG_W-1:0]          w_seg_nxt;

    logic [IN_TDATA_WIDTH-1:0] r_data;
    logic [IN_KEEP_W-1:0]      r_keep;
    logic [TUSER_WIDTH-1:0]    r_user;
    logic                      r_last;

    logic                      w_final;
    logic                      w_hold;
    logic                      w_narrow_fire;
    logic                      w_wide_ready;
    logic                      w_wide_fire;
    logic [OUT_TDATA_WIDTH-1:0] w_seg_data;
    logic [OUT_KEEP_W-1:0]     w_seg_keep;

`ifdef AXIS_SPLITTER_SKIP_EMPTY_EN
    // Final when on the last slot, or nothing valid remains above this segment.
    function automatic logic f_is_final(input logic [SEG_W-1:0]     seg,
                                        input logic [IN_KEEP_W-1:0] keep);
        logic upper_any;
        upper_any = 1'b0;
        for (int b = 0; b < IN_KEEP_W; b++) begin
            if (b >= (int'(seg) + 1) * OUT_KEEP_W) begin
                upper_any = upper_any | keep[b];
            end
        end
        return (seg == SEG_LAST) || !upper_any;
    endfunction

    assign w_final = f_is_final(r_seg, r_keep);
`else
    function automatic logic f_is_final(input logic [SEG_W-1:0] seg);
        return (seg == SEG_LAST);
    endfunction

    assign w_final = f_is_final(r_seg);
`endif

    assign w_hold        = (r_state == AXIS_ST_HOLD);
    assign w_narrow_fire = w_hold && axis_narrow_tready;

    // Reload is allowed in the same cycle the final segment leaves.
    assign w_wide_ready  = axis_resetn &&
                           ((r_state == AXIS_ST_EMPTY) || (w_final && w_narrow_fire));
    assign w_wide_fire   = axis_wide_tvalid && w_wide_ready;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= AXIS_ST_EMPTY;
            r_seg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_seg_nxt   = r_seg;
        case (r_state)
            AXIS_ST_EMPTY: begin
                if (w_wide_fire) begin
                    w_state_nxt = AXIS_ST_HOLD;
                    w_seg_nxt   = '0;
                end
            end
            AXIS_ST_HOLD: begin
                if (w_narrow_fire) begin
                    if (w_final) begin
                        w_seg_nxt   = '0;
                        w_state_nxt = w_wide_fire ? AXIS_ST_HOLD : AXIS_ST_EMPTY;
                    end else begin
                        w_seg_nxt   = r_seg + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = AXIS_ST_EMPTY;
                w_seg_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_data <= '0;
            r_keep <= '0;
            r_user <= '0;
            r_last <= 1'b0;
        end else if (w_wide_fire) begin
            r_data <= axis_wide_tdata;
            r_keep <= axis_wide_tkeep;
            r_user <= axis_wide_tuser;
            r_last <= axis_wide_tlast;
        end
    end

    always_comb begin
        w_seg_data = '0;
        w_seg_keep = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (r_seg == SEG_W'(i)) begin
                w_seg_data = r_data[i*OUT_TDATA_WIDTH +: OUT_TDATA_WIDTH];
                w_seg_keep = r_keep[i*OUT_KEEP_W +: OUT_KEEP_W];
            end
        end
    end

    assign axis_wide_tready   = w_wide_ready;
    assign axis_narrow_tdata  = w_seg_data;
    assign axis_narrow_tkeep  = w_seg_keep;
    assign axis_narrow_tuser  = r_user;
    assign axis_narrow_tvalid = w_hold;
    assign axis_narrow_tlast  = w_hold && w_final && r_last;

endmodule : axis_splitter

`default_nettype wire
